// File: rtl/lsu_bus_master.sv
// -----------------------------------------------------------------------------
// lsu_bus_master
//   Data-side load/store unit. Converts one load or store from the execute
//   stage into a single valid/ready transaction on the data-memory bus,
//   handles byte/half/word lanes and load sign/zero extension, freezes the
//   pipeline until the access completes, and flags misaligned accesses,
//   illegal funct3 encodings and bus timeouts.
//
// Parameters
//   TIMEOUT_CYC    cycles allowed in REQ+WAIT before the access is aborted;
//                  0 disables the timeout
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   read_en        load request (held by the controller while stall=1)
//   write_en       store request (held by the controller while stall=1)
//   funct3         000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata    byte address and store data from execute
//   rdata          extended load result, held until the next load completes
//   stall          1 = freeze PC and pipeline registers
//   exc_pulse      one-cycle exception strobe
//   exc_cause      01 misaligned, 10 illegal funct3, 11 bus timeout
//   mem_req_*      request channel (valid/ready, we, word address, data, strobes)
//   mem_rsp_*      read response channel
// -----------------------------------------------------------------------------
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        exc_pulse,
  output logic [1:0]  exc_cause,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // The counter can run one step past the limit (handshake exactly at the
  // limit, then one WAIT cycle), so it needs room for TIMEOUT_CYC+2.
  localparam int unsigned     CNT_W      = $clog2(TIMEOUT_CYC + 3);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYC != 32'd0);

  // Size encoding legality; BU/HU exist only for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~is_store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment for the access size held in f3[1:0].
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3[1:0])
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << {a[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Store data replicated across all lanes so any strobe pattern sees it.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed lane out of the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [2:0]       f3_r;
  logic [1:0]       off_r;
  logic             req_s;
  logic             is_store_s;
  logic             start_s;
  logic             exc_s;
  logic [1:0]       cause_s;
  logic             to_hit_s;
  logic             timeout_s;

  assign req_s      = write_en | read_en;
  assign is_store_s = write_en;                 // a store wins when both are set
  assign cnt_inc_s  = cnt_r + CNT_ONE;
  assign to_hit_s   = TIMEOUT_EN && (cnt_inc_s >= CNT_LIMIT);

  // Next-state, request acceptance and exception decode.
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    exc_s     = 1'b0;
    cause_s   = 2'b00;
    timeout_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!req_s) begin
          state_s = S_IDLE;
        end else if (!f3_legal(is_store_s, funct3)) begin
          exc_s   = 1'b1;
          cause_s = 2'b10;
        end else if (!addr_aligned(funct3, addr[1:0])) begin
          exc_s   = 1'b1;
          cause_s = 2'b01;
        end else begin
          start_s = 1'b1;
          state_s = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_s = mem_we ? S_DONE : S_WAIT;
        end else if (to_hit_s) begin
          timeout_s = 1'b1;
          exc_s     = 1'b1;
          cause_s   = 2'b11;
          state_s   = S_DONE;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_s = S_DONE;
        end else if (to_hit_s) begin
          timeout_s = 1'b1;
          exc_s     = 1'b1;
          cause_s   = 2'b11;
          state_s   = S_DONE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DONE: begin
        // The same instruction is still presented; let it retire.
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Stall and exception are combinational so the pipeline reacts in the
  // request cycle; reset forces them low even while enables are still high.
  assign stall         = rst_n & (start_s | (state_r == S_REQ) | (state_r == S_WAIT));
  assign exc_pulse     = rst_n & exc_s;
  assign exc_cause     = exc_pulse ? cause_s : 2'b00;
  assign mem_req_valid = (state_r == S_REQ);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request fields captured once at acceptance and held through the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= 32'd0;
      mem_we    <= 1'b0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      f3_r      <= 3'd0;
      off_r     <= 2'd0;
    end else if (start_s) begin
      mem_addr  <= {addr[31:2], 2'b00};
      mem_we    <= is_store_s;
      mem_wdata <= is_store_s ? lane_wdata(funct3, wdata) : 32'd0;
      mem_wstrb <= is_store_s ? lane_strb(funct3, addr[1:0]) : 4'd0;
      f3_r      <= funct3;
      off_r     <= addr[1:0];
    end
  end

  // Timeout counter: cleared on acceptance, counts every REQ/WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (start_s) begin
      cnt_r <= '0;
    end else if ((state_r == S_REQ) || (state_r == S_WAIT)) begin
      cnt_r <= cnt_inc_s;
    end
  end

  // Load result register; an aborted access leaves zero behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'd0;
    end else if (timeout_s) begin
      rdata <= 32'd0;
    end else if ((state_r == S_WAIT) && mem_rsp_valid) begin
      rdata <= load_extend(f3_r, off_r, mem_rsp_data);
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT (default timeout)
  logic        read_en, write_en;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, exc_pulse;
  logic [1:0]  exc_cause;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_wstrb;

  // short-timeout DUT
  logic        t_read_en, t_write_en;
  logic [2:0]  t_funct3;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic        t_stall, t_exc_pulse;
  logic [1:0]  t_exc_cause;
  logic        t_valid, t_ready, t_we, t_rsp_valid;
  logic [31:0] t_mem_addr, t_mem_wdata, t_rsp_data;
  logic [3:0]  t_wstrb;

  lsu_bus_master u_dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .exc_pulse(exc_pulse), .exc_cause(exc_cause),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data)
  );

  lsu_bus_master #(.TIMEOUT_CYC(4)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .read_en(t_read_en), .write_en(t_write_en),
    .funct3(t_funct3), .addr(t_addr), .wdata(t_wdata), .rdata(t_rdata),
    .stall(t_stall), .exc_pulse(t_exc_pulse), .exc_cause(t_exc_cause),
    .mem_req_valid(t_valid), .mem_req_ready(t_ready),
    .mem_we(t_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_wstrb(t_wstrb), .mem_rsp_valid(t_rsp_valid),
    .mem_rsp_data(t_rsp_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b1;
    if (!st && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(f3)) == 0;
  endfunction

  function automatic int lane_base(input logic [2:0] f3, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    return o - (o % nbytes(f3));
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = nbytes(f3);
    return 4'(((1 << n) - 1) << lane_base(f3, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] word);
    logic [31:0] v, mask;
    int n;
    n = nbytes(f3);
    v = word >> (8 * lane_base(f3, a));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- expectations + per-cycle compare ----------------
  bit          chk_en = 1'b0;
  logic        exp_stall, exp_valid, exp_exc, exp_we;
  logic [1:0]  exp_cause;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, exp_stall);
      chk("mem_req_valid", mem_req_valid, exp_valid);
      chk("exc_pulse", exc_pulse, exp_exc);
      if (exp_exc) chk("exc_cause", exc_cause, exp_cause);
      chk("rdata", rdata, exp_rdata);
      if (exp_valid) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", mem_we, exp_we);
        chk("mem_wstrb", mem_wstrb, exp_wstrb);
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  // captures for the literal pins
  logic [7:0]  stall_hist;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_exc;
  logic [1:0]  cap_cause;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #3;
    stall_hist = {stall_hist[6:0], stall};
  endtask

  task automatic idle_cycle();
    next_cycle();
    read_en = 1'b0; write_en = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_exc = 1'b0;
  endtask

  // One instruction: request cycle, bus phases, release cycle, then idle.
  task automatic run_op(input bit st, input bit ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int rdy_wait, input int rsp_wait, input logic [31:0] rsp);
    bit is_st;
    is_st = st;
    stall_hist = 8'd0;
    next_cycle();
    write_en = st; read_en = ld; funct3 = f3; addr = a; wdata = wd;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    exp_valid = 1'b0;
    if (!m_legal(is_st, f3)) begin
      exp_exc = 1'b1; exp_cause = 2'b10; exp_stall = 1'b0;
    end else if (!m_aligned(f3, a)) begin
      exp_exc = 1'b1; exp_cause = 2'b01; exp_stall = 1'b0;
    end else begin
      exp_exc = 1'b0; exp_stall = 1'b1;
    end
    sample();
    cap_exc = exc_pulse;
    cap_cause = exc_cause;
    if (!exp_exc) begin
      exp_addr  = a & 32'hFFFF_FFFC;
      exp_we    = is_st;
      exp_wstrb = is_st ? m_strb(f3, a) : 4'd0;
      exp_wdata = m_wdata(f3, wd);
      for (int k = 0; k <= rdy_wait; k++) begin
        next_cycle();
        exp_valid = 1'b1; exp_stall = 1'b1;
        mem_req_ready = (k == rdy_wait);
        mem_rsp_valid = 1'b1;                       // must be ignored outside WAIT
        mem_rsp_data  = 32'h5A5A_5A5A ^ k;
        sample();
        if (k == 0) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
        end
      end
      if (!is_st) begin
        for (int k = 0; k <= rsp_wait; k++) begin
          next_cycle();
          mem_req_ready = 1'b0;
          exp_valid = 1'b0; exp_stall = 1'b1;
          mem_rsp_valid = (k == rsp_wait);
          mem_rsp_data  = (k == rsp_wait) ? rsp : 32'hFFFF_0000;
          sample();
        end
      end
      next_cycle();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;                         // ignored in DONE
      mem_rsp_data  = 32'h1111_1111;
      exp_stall = 1'b0; exp_valid = 1'b0;
      if (!is_st) exp_rdata = m_load(f3, a, rsp);
      sample();
    end
    idle_cycle();
  endtask

  // short-timeout DUT cycle table (bit c = cycle c)
  logic [16:0] t_ready_v = 17'b00100000000000010;
  logic [16:0] t_rspv_v  = 17'b01000000000000100;
  logic [16:0] t_valid_v = 17'b00111100111100010;
  logic [16:0] t_stall_v = 17'b01111110111110111;
  logic [16:0] t_exc_v   = 17'b00000000100000000;

  initial begin
    read_en = 1'b1; write_en = 1'b0; funct3 = 3'b010; addr = 32'h100; wdata = 32'h0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
    t_read_en = 1'b0; t_write_en = 1'b0; t_funct3 = 3'b010; t_addr = 32'h40;
    t_wdata = 32'h0; t_ready = 1'b0; t_rsp_valid = 1'b0; t_rsp_data = 32'h0;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_exc = 1'b0; exp_cause = 2'b00;
    exp_rdata = 32'h0; exp_addr = 32'h0; exp_we = 1'b0; exp_wdata = 32'h0; exp_wstrb = 4'h0;
    stall_hist = 8'd0;

    // reset state, with a legal load presented
    #3;
    chk("rst_stall", stall, 32'd0);
    chk("rst_valid", mem_req_valid, 32'd0);
    chk("rst_exc", exc_pulse, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wstrb", mem_wstrb, 32'd0);
    chk("rst_we", mem_we, 32'd0);
    chk("rst_t_valid", t_valid, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1; read_en = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk_en = 1'b1;

    // loads
    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    chk("lw_stall_seq", {28'd0, stall_hist[3:0]}, 32'h0000_000E);
    chk("lw_addr", cap_addr, 32'h0000_0100);
    chk("lw_rdata", rdata, 32'hDEAD_BEEF);
    run_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    run_op(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    run_op(1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80FF_0000);
    chk("lhu_rdata", rdata, 32'h0000_80FF);
    run_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80FF_0000);
    run_op(1'b0, 1'b1, 3'b000, 32'h101, 32'h0, 1, 0, 32'h0000_F700);
    run_op(1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 5, 2, 32'h1357_9BDF);

    // stores
    run_op(1'b1, 1'b0, 3'b000, 32'h21, 32'h1234_5678, 0, 0, 32'h0);
    chk("sb_stall_seq", {29'd0, stall_hist[2:0]}, 32'h0000_0006);
    chk("sb_wstrb", cap_wstrb, 32'h0000_0002);
    chk("sb_wdata", cap_wdata, 32'h7878_7878);
    chk("sb_addr", cap_addr, 32'h0000_0020);
    run_op(1'b1, 1'b0, 3'b001, 32'h22, 32'hAABB_CCDD, 0, 0, 32'h0);
    run_op(1'b1, 1'b1, 3'b010, 32'h44, 32'h0BAD_F00D, 2, 0, 32'h0);

    // exceptions
    run_op(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0);
    chk("lw_mis_exc", cap_exc, 32'd1);
    chk("lw_mis_cause", cap_cause, 32'd1);
    run_op(1'b1, 1'b0, 3'b100, 32'h40, 32'h0, 0, 0, 32'h0);
    chk("st_f3_cause", cap_cause, 32'd2);
    run_op(1'b1, 1'b1, 3'b100, 32'h40, 32'h0, 0, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'b011, 32'h40, 32'h0, 0, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'b110, 32'h40, 32'h0, 0, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'b001, 32'h23, 32'h0, 0, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'b111, 32'h3, 32'h0, 0, 0, 32'h0);

    // reset while in WAIT with the load still presented
    next_cycle();
    read_en = 1'b1; funct3 = 3'b010; addr = 32'h80;
    exp_stall = 1'b1; exp_valid = 1'b0; exp_exc = 1'b0;
    next_cycle();
    mem_req_ready = 1'b1; exp_valid = 1'b1; exp_addr = 32'h80; exp_we = 1'b0; exp_wstrb = 4'd0;
    next_cycle();
    mem_req_ready = 1'b0; exp_valid = 1'b0; exp_stall = 1'b1;
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstw_stall", stall, 32'd0);
    chk("rstw_valid", mem_req_valid, 32'd0);
    chk("rstw_rdata", rdata, 32'd0);
    chk("rstw_addr", mem_addr, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1; read_en = 1'b0;
    exp_rdata = 32'd0; exp_stall = 1'b0; exp_valid = 1'b0; exp_exc = 1'b0;
    chk_en = 1'b1;
    next_cycle();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
    next_cycle();
    next_cycle();
    mem_rsp_valid = 1'b0;

    // reset while in REQ with ready low
    next_cycle();
    read_en = 1'b1; funct3 = 3'b010; addr = 32'h84; exp_stall = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0; exp_valid = 1'b1; exp_addr = 32'h84;
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstq_valid", mem_req_valid, 32'd0);
    chk("rstq_stall", stall, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1; read_en = 1'b0;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_exc = 1'b0;
    chk_en = 1'b1;
    idle_cycle();
    run_op(1'b0, 1'b1, 3'b010, 32'h88, 32'h0, 0, 0, 32'h2468_ACE0);

    // short-timeout DUT: prime rdata, time out, then handshake/response at the limit
    for (int c = 0; c < 17; c++) begin
      logic [31:0] t_exp_rdata;
      @(posedge clk);
      #1;
      t_read_en = 1'b1; t_funct3 = 3'b010; t_addr = 32'h40;
      t_ready = t_ready_v[c];
      t_rsp_valid = t_rspv_v[c];
      t_rsp_data = (c < 5) ? 32'hA5A5_0001 : 32'h0000_1234;
      #3;
      if (c < 3) t_exp_rdata = 32'h0;
      else if (c < 9) t_exp_rdata = 32'hA5A5_0001;
      else if (c < 16) t_exp_rdata = 32'h0;
      else t_exp_rdata = 32'h0000_1234;
      chk($sformatf("to_valid_c%0d", c), t_valid, {31'd0, t_valid_v[c]});
      chk($sformatf("to_stall_c%0d", c), t_stall, {31'd0, t_stall_v[c]});
      chk($sformatf("to_exc_c%0d", c), t_exc_pulse, {31'd0, t_exc_v[c]});
      if (t_exc_v[c]) chk($sformatf("to_cause_c%0d", c), t_exc_cause, 32'd3);
      if (t_valid_v[c]) chk($sformatf("to_addr_c%0d", c), t_mem_addr, 32'h0000_0040);
      chk($sformatf("to_rdata_c%0d", c), t_rdata, t_exp_rdata);
    end
    @(posedge clk);
    #1;
    t_read_en = 1'b0; t_ready = 1'b0; t_rsp_valid = 1'b0;
    idle_cycle();
    idle_cycle();
    @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
